// File: rtl/instr_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_stage_pkg
// Description : Shared definitions for the instruction fetch stage: the
//               instruction field positions, the default PC step, the FSM
//               state encoding and a PC alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_stage_pkg;

  // Field positions inside a 16-bit instruction word
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // 16-bit instructions in a byte-addressed space advance the PC by 2
  localparam int unsigned PC_STEP_DFLT = 2;

  // Instructions are halfword aligned, so PC bit 0 is always zero
  localparam logic [15:0] PC_ALIGN_MASK = 16'hFFFE;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  // Force an address onto a halfword boundary
  function automatic logic [15:0] align_pc(input logic [15:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_stage_pc_counter.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_stage_pc_counter
// Description : Program counter. Loads an aligned redirect address, or
//               advances by PC_STEP with natural 16-bit wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_stage_pc_counter
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = PC_STEP_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [15:0] load_addr_i,
  input  logic        inc_i,
  output logic [15:0] pc_o
);

  localparam logic [15:0] C_STEP = 16'(PC_STEP);

  logic [15:0] pc_q;
  logic [15:0] pc_d;

  // Next PC: a load wins over an increment; bit 0 is cleared on every load
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = align_pc(load_addr_i);
    end else if (inc_i) begin
      pc_d = pc_q + C_STEP;
    end
  end

  // PC register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_stage
// Description : Fetches 16-bit instructions over a req/ready handshake into
//               an instruction register, owns the PC, applies branch
//               redirects (discarding an in-flight response when needed) and
//               splits the held instruction into opcode / rd / imm8.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = PC_STEP_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        branch_valid,
  input  logic [15:0] branch_target,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [7:0]  imm8,
  output logic [15:0] pc,
  output logic        busy
);

  state_e      state_q,       state_d;
  logic        discard_q,     discard_d;
  logic [15:0] redirect_q,    redirect_d;
  logic [15:0] instr_q,       instr_d;
  logic        instr_valid_q, instr_valid_d;

  logic        pc_load;
  logic [15:0] pc_load_addr;
  logic        pc_inc;
  logic [15:0] pc_cur;

  instr_fetch_stage_pc_counter #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_counter (
    .clk         (clk),
    .reset       (reset),
    .load_i      (pc_load),
    .load_addr_i (pc_load_addr),
    .inc_i       (pc_inc),
    .pc_o        (pc_cur)
  );

  // Next-state logic: fetch FSM, branch-during-request discard, instr register
  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    redirect_d    = redirect_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_load       = 1'b0;
    pc_load_addr  = branch_target;
    pc_inc        = 1'b0;

    case (state_q)
      IDLE: begin
        // A branch takes priority and drops any fetch request in this cycle;
        // mem_ready is not looked at here, so stray responses are ignored.
        if (branch_valid) begin
          pc_load       = 1'b1;
          instr_valid_d = 1'b0;
        end else if (fetch_en) begin
          state_d       = REQ;
          instr_valid_d = 1'b0;
        end
      end

      REQ: begin
        if (mem_ready) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          if (branch_valid) begin
            // Branch coincident with the response: response is stale
            pc_load = 1'b1;
          end else if (discard_q) begin
            // An earlier branch made this response stale; resume at target
            pc_load      = 1'b1;
            pc_load_addr = redirect_q;
          end else begin
            instr_d       = mem_rdata;
            instr_valid_d = 1'b1;
            pc_inc        = 1'b1;
          end
        end else if (branch_valid) begin
          // Keep mem_addr stable until the handshake; remember the latest
          // target and throw the response away when it arrives.
          redirect_d = align_pc(branch_target);
          discard_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      discard_q     <= 1'b0;
      redirect_q    <= 16'h0000;
      instr_q       <= 16'h0000;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      discard_q     <= discard_d;
      redirect_q    <= redirect_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign mem_req     = (state_q == REQ);
  assign busy        = (state_q == REQ);
  assign mem_addr    = pc_cur;
  assign pc          = pc_cur;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = instr_q[OPC_MSB:OPC_LSB];
  assign rd          = instr_q[RD_MSB:RD_LSB];
  assign imm8        = instr_q[IMM_MSB:IMM_LSB];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_stage
// Description : Directed scoreboard bench for instr_fetch_stage. Stimulus
//               queues hand-computed expectations; a negedge monitor pops
//               and compares them, and checks mem_addr on every new request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [7:0]  imm8;
  logic [15:0] pc;
  logic        busy;

  // Downstream 8-to-16 zero extender fed by imm8
  logic [15:0] zext;
  assign zext = {8'h00, imm8};

  instr_fetch_stage #(
    .RESET_PC (16'h0000),
    .PC_STEP  (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .rd            (rd),
    .imm8          (imm8),
    .pc            (pc),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       name;
    logic [15:0] instr;
    logic        iv;
    logic [15:0] pc;
    logic        mreq;
    logic [3:0]  opc;
    logic [3:0]  rd;
    logic [7:0]  imm;
    logic [15:0] zext;
  } exp_t;

  exp_t        sq[$];
  logic [15:0] addr_q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        prev_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare due expectations and the address of each new request
  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0].due <= cyc) begin
      exp_t e;
      e = sq.pop_front();
      if (e.due < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: expectation stale, due %0d now %0d", e.name, e.due, cyc);
      end else begin
        chk({e.name, ".instr"},  instr,               e.instr);
        chk({e.name, ".valid"},  {15'h0, instr_valid}, {15'h0, e.iv});
        chk({e.name, ".pc"},     pc,                  e.pc);
        chk({e.name, ".memreq"}, {15'h0, mem_req},    {15'h0, e.mreq});
        chk({e.name, ".busy"},   {15'h0, busy},       {15'h0, e.mreq});
        chk({e.name, ".opcode"}, {12'h0, opcode},     {12'h0, e.opc});
        chk({e.name, ".rd"},     {12'h0, rd},         {12'h0, e.rd});
        chk({e.name, ".imm8"},   {8'h0, imm8},        {8'h0, e.imm});
        chk({e.name, ".zext"},   zext,                e.zext);
      end
    end
    if (mem_req && !prev_req) begin
      if (addr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mem_addr: unexpected request at %h", mem_addr);
      end else begin
        chk("mem_addr", mem_addr, addr_q.pop_front());
      end
    end
    prev_req <= mem_req;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string nm, input logic [15:0] ins, input logic iv,
                            input logic [15:0] p, input logic mr, input logic [3:0] o,
                            input logic [3:0] r, input logic [7:0] im, input logic [15:0] z);
    exp_t e;
    e.due = cyc; e.name = nm; e.instr = ins; e.iv = iv; e.pc = p; e.mreq = mr;
    e.opc = o; e.rd = r; e.imm = im; e.zext = z;
    sq.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fetch_en = 1'b0; branch_valid = 1'b0; branch_target = 16'h0000;
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    step(2);
    expect_now("reset", 16'h0000, 0, 16'h0000, 0, 4'h0, 4'h0, 8'h00, 16'h0000);
    reset = 1'b0;
    step(1);

    // Basic fetch, memory answers two cycles after the request
    fetch_en = 1'b1; addr_q.push_back(16'h0000);
    step(1);
    fetch_en = 1'b0;
    expect_now("fetch1_req", 16'h0000, 0, 16'h0000, 1, 4'h0, 4'h0, 8'h00, 16'h0000);
    step(1);
    mem_ready = 1'b1; mem_rdata = 16'h5A3C;
    step(1);
    mem_ready = 1'b0;
    expect_now("fetch1_done", 16'h5A3C, 1, 16'h0002, 0, 4'h5, 4'hA, 8'h3C, 16'h003C);

    // Branch during REQ, response one cycle later is discarded
    fetch_en = 1'b1; addr_q.push_back(16'h0002);
    step(1);
    fetch_en = 1'b0;
    branch_valid = 1'b1; branch_target = 16'h0101;
    step(1);
    branch_valid = 1'b0;
    expect_now("branch_req", 16'h5A3C, 0, 16'h0002, 1, 4'h5, 4'hA, 8'h3C, 16'h003C);
    mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    step(1);
    mem_ready = 1'b0;
    expect_now("branch_done", 16'h5A3C, 0, 16'h0100, 0, 4'h5, 4'hA, 8'h3C, 16'h003C);

    // Wrap-around from 16'hFFFE
    branch_valid = 1'b1; branch_target = 16'hFFFE;
    step(1);
    branch_valid = 1'b0;
    expect_now("wrap_branch", 16'h5A3C, 0, 16'hFFFE, 0, 4'h5, 4'hA, 8'h3C, 16'h003C);
    fetch_en = 1'b1; addr_q.push_back(16'hFFFE);
    step(1);
    fetch_en = 1'b0;
    step(1);
    mem_ready = 1'b1; mem_rdata = 16'h12FF;
    step(1);
    mem_ready = 1'b0;
    expect_now("wrap_done", 16'h12FF, 1, 16'h0000, 0, 4'h1, 4'h2, 8'hFF, 16'h00FF);

    // Simultaneous fetch_en and branch in IDLE: branch wins, fetch dropped
    fetch_en = 1'b1; branch_valid = 1'b1; branch_target = 16'h0040;
    step(1);
    fetch_en = 1'b0; branch_valid = 1'b0;
    expect_now("simul", 16'h12FF, 0, 16'h0040, 0, 4'h1, 4'h2, 8'hFF, 16'h00FF);
    fetch_en = 1'b1; addr_q.push_back(16'h0040);
    step(1);
    fetch_en = 1'b0;
    expect_now("simul_req", 16'h12FF, 0, 16'h0040, 1, 4'h1, 4'h2, 8'hFF, 16'h00FF);
    step(1);
    mem_ready = 1'b1; mem_rdata = 16'h9876;
    step(1);
    mem_ready = 1'b0;
    expect_now("simul_done", 16'h9876, 1, 16'h0042, 0, 4'h9, 4'h8, 8'h76, 16'h0076);

    // Reset while mem_req is high, then a late response
    fetch_en = 1'b1; addr_q.push_back(16'h0042);
    step(1);
    fetch_en = 1'b0; reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_now("rst_req", 16'h0000, 0, 16'h0000, 0, 4'h0, 4'h0, 8'h00, 16'h0000);
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    step(1);
    mem_ready = 1'b0;
    expect_now("rst_late", 16'h0000, 0, 16'h0000, 0, 4'h0, 4'h0, 8'h00, 16'h0000);

    // Load a valid instruction, then stray mem_ready in IDLE
    fetch_en = 1'b1; addr_q.push_back(16'h0000);
    step(1);
    fetch_en = 1'b0;
    step(1);
    mem_ready = 1'b1; mem_rdata = 16'h4321;
    step(1);
    expect_now("stray_pre", 16'h4321, 1, 16'h0002, 0, 4'h4, 4'h3, 8'h21, 16'h0021);
    mem_rdata = 16'h7777;
    step(1);
    expect_now("stray1", 16'h4321, 1, 16'h0002, 0, 4'h4, 4'h3, 8'h21, 16'h0021);
    step(1);
    mem_ready = 1'b0;
    expect_now("stray2", 16'h4321, 1, 16'h0002, 0, 4'h4, 4'h3, 8'h21, 16'h0021);

    step(3);
    if (sq.size() != 0 || addr_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d state and %0d address expectations left", sq.size(), addr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Fetches 16-bit instructions from instruction memory over a req/ready handshake and holds each one in an instruction register.
- Owns the PC and applies branch redirects.
- Splits the held instruction into opcode, rd and imm8 fields.
- Directly upstream of the 8-to-16 zero extender, whose 8-bit input is driven by imm8; opcode and rd go to control and register-file decode.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 2, byte increment per instruction (16-bit words, byte-addressed)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
fetch_en  in  1  controller requests the next instruction
branch_valid  in  1  redirect PC this cycle
branch_target  in  16  redirect address; bit 0 ignored and forced 0
mem_req  out  1  memory read request
mem_addr  out  16  read address, equals pc while mem_req high
mem_ready  in  1  memory response valid, qualifies mem_rdata
mem_rdata  in  16  instruction word from memory
instr  out  16  instruction register
instr_valid  out  1  instr holds a fetched, not-yet-superseded instruction
opcode  out  4  instr[15:12]
rd  out  4  instr[11:8]
imm8  out  8  instr[7:0], feeds zero extender input
pc  out  16  address of next fetch
busy  out  1  high in REQ state

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All flops update on the rising edge of clk.
- Reset values: pc=RESET_PC, instr=16'h0000, instr_valid=0, mem_req=0, busy=0, state=IDLE, discard=0.
- Reset mid-REQ: mem_req drops on the same edge. Any later mem_ready seen in IDLE is ignored.
- FSM states are IDLE and REQ.
- IDLE:
  - branch_valid=1: pc<=branch_target&16'hFFFE, instr_valid<=0, stay IDLE. Branch has priority over fetch_en in the same cycle; the fetch is dropped and the controller must re-assert fetch_en.
  - Else fetch_en=1: go REQ, instr_valid<=0.
  - mem_ready in IDLE is ignored.
- REQ:
  - mem_req=1 and mem_addr=pc, both stable until the handshake cycle.
  - Handshake completes in the first REQ cycle with mem_ready=1. Memory latency is at least 1 cycle after mem_req first rises; it is never combinational.
  - On handshake with discard=0: instr<=mem_rdata, instr_valid<=1, pc<=pc+PC_STEP (16-bit wrap, 16'hFFFE -> 16'h0000), go IDLE.
  - branch_valid=1 in REQ without handshake: pc_redirect<=target, discard<=1, stay REQ. mem_addr keeps the original address until the handshake.
  - On handshake with discard=1: mem_rdata dropped, pc<=pc_redirect, discard<=0, instr_valid stays 0, go IDLE.
  - branch_valid coincident with handshake: response discarded, pc<=branch_target, go IDLE.
  - A second branch while discard=1 overwrites pc_redirect (last wins).
- Latency: instr_valid rises one cycle after the handshake cycle. Minimum fetch takes 3 cycles from fetch_en to instr_valid.
- Outputs:
  - opcode, rd and imm8 are combinational slices of the instr register; they are stable while instr_valid=1 and are not gated by instr_valid.
  - busy = (state==REQ).
  - fetch_en asserted during REQ is ignored, so there is no queueing.

Decomposition:
- Shared package holds:
  - field position constants: OPC_MSB=15, OPC_LSB=12, RD_MSB=11, RD_LSB=8, IMM_MSB=7, IMM_LSB=0
  - PC_STEP default
  - state encoding: IDLE=1'b0, REQ=1'b1
- Natural sub-module: pc_counter, which handles load (reset/redirect), increment with wrap, and bit-0 masking.
- FSM, discard logic and instruction register stay in the top module.

Test Plan:
- Reset, then fetch_en pulse; memory returns 16'h5A3C after 2 cycles -> mem_addr=16'h0000, then instr=16'h5A3C, opcode=4'h5, rd=4'hA, imm8=8'h3C, instr_valid=1, pc=16'h0002; the downstream zero extender shows 16'h003C.
- Branch during REQ: branch_target=16'h0101 arrives 1 cycle before mem_ready returning 16'hFFFF -> instr unchanged, instr_valid=0, pc=16'h0100.
- Wrap-around: branch to 16'hFFFE, fetch returns 16'h12FF -> pc=16'h0000, imm8=8'hFF.
- Simultaneous fetch_en and branch_valid (target 16'h0040) in IDLE -> no mem_req that cycle, pc=16'h0040; the next fetch_en gives mem_addr=16'h0040.
- Reset asserted while mem_req=1, then mem_ready pulse with 16'hBEEF -> mem_req=0 after the reset edge, instr=16'h0000, instr_valid=0, pc=RESET_PC.
- Stray mem_ready in IDLE with 16'h7777 -> instr, instr_valid and pc unchanged.
